// File: rtl/decode_branch_unit_if.sv
// Fetch/decode/EX/MEM signals of the decode branch unit, grouped as one bundle.
// The master side feeds fetch and pipeline state; the slave side is the decode unit.
interface decode_branch_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      PC;
  logic [31:0]      instruction;
  logic [31:0]      rd1D;
  logic [31:0]      rd2D;
  logic             MemReadE;
  logic             RegWriteE;
  logic [4:0]       WriteRegE;
  logic             MemReadM;
  logic             RegWriteM;
  logic [4:0]       WriteRegM;
  logic [31:0]      ALUOutM;
  logic [31:0]      instrD;
  logic [31:0]      PCPlus4D;
  logic [31:0]      PCBranchD;
  logic             PCSrcD;
  logic             write;
  logic             hazardDetected;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] redirectCount;

  modport master (
    output PC, instruction, rd1D, rd2D, MemReadE, RegWriteE, WriteRegE,
           MemReadM, RegWriteM, WriteRegM, ALUOutM,
    input  instrD, PCPlus4D, PCBranchD, PCSrcD, write, hazardDetected,
           stallCount, redirectCount
  );

  modport slave (
    input  PC, instruction, rd1D, rd2D, MemReadE, RegWriteE, WriteRegE,
           MemReadM, RegWriteM, WriteRegM, ALUOutM,
    output instrD, PCPlus4D, PCBranchD, PCSrcD, write, hazardDetected,
           stallCount, redirectCount
  );
endinterface

// File: rtl/decode_branch_unit.sv
// Decode-stage branch resolution: IF/ID register, beq/bne/j redirect, hazard
// detection, M-stage forwarding into the comparator and saturating perf counters.
module decode_branch_unit #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  decode_branch_unit_if.slave  bus
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpSw    = 6'b101011;

  logic [31:0]      instr_q;
  logic [31:0]      pc4_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] redir_cnt_q;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        is_beq, is_bne, is_j, is_branch;
  logic        uses_rs, uses_rt;
  logic        e_rs, e_rt, m_rs, m_rt;
  logic        load_use, branch_haz, stall;
  logic [31:0] op_a, op_b;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        taken, pcsrc;

  assign op = instr_q[31:26];
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  always_comb begin
    is_beq    = (op == OpBeq);
    is_bne    = (op == OpBne);
    is_j      = (op == OpJ);
    is_branch = is_beq | is_bne;
    // Only J-format opcodes leave the rs field unused.
    uses_rs   = (op != OpJ) && (op != OpJal);
    uses_rt   = (op == OpRtype) | is_branch | (op == OpSw);

    // $0 is hardwired, so a write to it never creates a dependency.
    e_rs = (bus.WriteRegE != 5'd0) && (bus.WriteRegE == rs);
    e_rt = (bus.WriteRegE != 5'd0) && (bus.WriteRegE == rt);
    m_rs = (bus.WriteRegM != 5'd0) && (bus.WriteRegM == rs);
    m_rt = (bus.WriteRegM != 5'd0) && (bus.WriteRegM == rt);

    load_use   = bus.MemReadE && ((uses_rs && e_rs) || (uses_rt && e_rt));
    branch_haz = is_branch && ((bus.RegWriteE && (e_rs || e_rt)) ||
                               (bus.MemReadM && (m_rs || m_rt)));
    stall      = load_use | branch_haz;

    op_a = (bus.RegWriteM && !bus.MemReadM && m_rs) ? bus.ALUOutM : bus.rd1D;
    op_b = (bus.RegWriteM && !bus.MemReadM && m_rt) ? bus.ALUOutM : bus.rd2D;

    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    target = pc4_q;
    if (is_branch) begin
      target = pc4_q + br_off;
    end else if (is_j) begin
      target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    end

    taken = is_j | (is_beq & (op_a == op_b)) | (is_bne & (op_a != op_b));
    pcsrc = !stall && taken;
  end

  assign bus.instrD         = instr_q;
  assign bus.PCPlus4D       = pc4_q;
  assign bus.PCBranchD      = target;
  assign bus.PCSrcD         = pcsrc;
  assign bus.write          = !stall;
  assign bus.hazardDetected = stall;
  assign bus.stallCount     = stall_cnt_q;
  assign bus.redirectCount  = redir_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc4_q   <= 32'h0;
    end else if (!stall) begin
      // A redirect squashes the single wrong-path fetch.
      instr_q <= pcsrc ? NOP : bus.instruction;
      pc4_q   <= bus.PC + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (pcsrc && (redir_cnt_q != '1)) begin
        redir_cnt_q <= redir_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/decode_branch_unit.md
# decode_branch_unit

Decode-stage partner of the instruction fetch stage. It owns the IF/ID pipeline register and consumes `PC`/`instruction` from fetch. It resolves beq/bne/j in decode and drives the fetch-side controls `PCBranchD`, `PCSrcD`, `write` and `hazardDetected`. It also detects load-use and branch-operand hazards, forwards the M-stage ALU result into the branch comparator, and keeps saturating stall and redirect counters for performance debug.

## Interface
- `NOP`, 32'h0000_0000, instruction word loaded into IF/ID on flush and reset
- `CNT_W`, 16, width of the performance counters
- `clk` in 1: the only clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `PC` in 32: byte address of the instruction currently in fetch
- `instruction` in 32: fetched instruction word
- `rd1D`, `rd2D` in 32: register-file read data for `instrD[25:21]` / `instrD[20:16]`
- `MemReadE`, `RegWriteE` in 1: EX-stage load / register-write flags
- `WriteRegE` in 5: EX-stage destination register
- `MemReadM`, `RegWriteM` in 1: MEM-stage load / register-write flags
- `WriteRegM` in 5: MEM-stage destination register
- `ALUOutM` in 32: MEM-stage ALU result
- `instrD` out 32: IF/ID instruction
- `PCPlus4D` out 32: IF/ID PC+4
- `PCBranchD` out 32: redirect target
- `PCSrcD` out 1: redirect fetch to `PCBranchD`
- `write` out 1: PC and IF/ID write enable
- `hazardDetected` out 1: stall this cycle; EX stage inserts a bubble
- `stallCount`, `redirectCount` out CNT_W: saturating counters

## Operation
- Decode: op = `instrD[31:26]`, rs = `[25:21]`, rt = `[20:16]`.
  - beq = 6'b000100, bne = 6'b000101, j = 6'b000010.
  - rs is used by R-type, I-type, beq and bne. rt is used by R-type, beq, bne and stores (op 101011).
  - j uses neither.
- Register $0 never matches any hazard or forwarding compare.
- Load-use hazard: `MemReadE` and `WriteRegE` equals a used rs or rt.
- Branch hazard (beq/bne only):
  - `RegWriteE` and `WriteRegE` equals rs or rt, or
  - `MemReadM` and `WriteRegM` equals rs or rt.
- Hazard condition: `write`=0, `hazardDetected`=1, `PCSrcD` forced to 0.
- No hazard: `write`=1, `hazardDetected`=0.
- Forwarding: compare operand A = `ALUOutM` if `RegWriteM` and not `MemReadM` and `WriteRegM`==rs (nonzero), else `rd1D`. Operand B is selected the same way with rt and `rd2D`.
- Branch target: `PCBranchD` = `PCPlus4D` + (sign-extended `instrD[15:0]` << 2), 32-bit wrap.
- Jump target: `PCBranchD` = {`PCPlus4D[31:28]`, `instrD[25:0]`, 2'b00}.
- Any other opcode: `PCBranchD` = `PCPlus4D`.
- `PCSrcD` = no hazard AND (j OR (beq AND A==B) OR (bne AND A!=B)).
- IF/ID update on each rising edge, in priority order:
  - stall (`write`=0): hold both registers;
  - else `PCSrcD`=1: `instrD`<=NOP, `PCPlus4D`<=`PC`+4 (flush the wrong-path fetch);
  - else `instrD`<=`instruction`, `PCPlus4D`<=`PC`+4.
- Counters:
  - `stallCount` increments on each cycle with `hazardDetected`=1.
  - `redirectCount` increments on each cycle with `PCSrcD`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous; outputs take these values immediately when `rst_n` falls, including mid-stall or mid-redirect):
  - `instrD`=NOP, `PCPlus4D`=0, counters=0.
  - Combinational outputs therefore settle to `write`=1, `hazardDetected`=0, `PCSrcD`=0, `PCBranchD`=0.
  - State is held until the first rising edge with `rst_n`=1.
- Branch resolution latency is zero cycles after `instrD` is valid. `PCSrcD`, `PCBranchD`, `write` and `hazardDetected` are purely combinational from the registers and EX/M inputs. Fetch samples them on the same edge.
- Taken branch or jump: exactly one wrong-path instruction is fetched and is squashed on the next edge.
- Stall and branch in the same cycle: the stall wins and the branch re-evaluates next cycle.
  - Load feeding a branch: 2 stall cycles (E hit, then M hit).
  - ALU result feeding a branch: 1 stall cycle, then forwarded from M.
- Back-to-back redirects are legal. A NOP in decode never causes a hazard.

## Test plan
- Reset: assert `rst_n`=0 mid-run while `PCSrcD`=1 -> all outputs immediately at reset values. After release, the first edge with `PC`=0, `instruction`=32'h012A4020 gives `instrD`=32'h012A4020, `PCPlus4D`=4.
- beq taken: `instrD`=32'h10220002, `PCPlus4D`=32'h14, `rd1D`=`rd2D`=5 -> `PCBranchD`=32'h1C, `PCSrcD`=1, `redirectCount`=1, next `instrD`=0. With `rd2D`=6 -> `PCSrcD`=0.
- Load-use: `MemReadE`=1, `WriteRegE`=9, `instrD`=32'h01284020 (rs=9) -> `write`=0, `hazardDetected`=1, IF/ID holds for that cycle, `stallCount`=1. With `WriteRegE`=0 -> no stall.
- Forwarded bne: `instrD`=32'h1464FFFF (rs=3, rt=4), `RegWriteM`=1, `WriteRegM`=3, `ALUOutM`=7, `rd1D`=0, `rd2D`=7, `PCPlus4D`=32'h20 -> `PCSrcD`=0. With `ALUOutM`=8 -> `PCSrcD`=1, `PCBranchD`=32'h1C.
- Jump: `instrD`=32'h08000040, `PCPlus4D`=32'h9000_0014 -> `PCBranchD`=32'h9000_0100, `PCSrcD`=1.
- Load into branch: `MemReadE`=1, `WriteRegE`=1 with beq rs=1 -> 1 stall. Then `MemReadM`=1, `WriteRegM`=1 -> 1 more stall, `stallCount`=2, then resolution. Force the counters to all-ones and stall once more -> they hold all-ones.
